// File: rtl/pp_gen_pkg.sv
// Shared definitions for the partial-product generator.
//   PP_MODE_AND / PP_MODE_BOOTH : values of the per-beat mode bit
//   booth_digit_e               : radix-4 Booth digit selected by one 3-bit group
//   booth_decode()              : maps {b[2j+1], b[2j], b[2j-1]} to its digit
package pp_gen_pkg;

  localparam logic PP_MODE_AND   = 1'b0;
  localparam logic PP_MODE_BOOTH = 1'b1;

  typedef enum logic [2:0] {
    BD_ZERO,
    BD_POS1,
    BD_POS2,
    BD_NEG1,
    BD_NEG2
  } booth_digit_e;

  function automatic booth_digit_e booth_decode(input logic [2:0] grp);
    booth_digit_e dig;
    unique case (grp)
      3'b001, 3'b010: dig = BD_POS1;
      3'b011:         dig = BD_POS2;
      3'b100:         dig = BD_NEG2;
      3'b101, 3'b110: dig = BD_NEG1;
      default:        dig = BD_ZERO;  // 000 and 111
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/booth_r4_row.sv
// One radix-4 Booth partial-product row.
//   a_i     : multiplicand, two's complement, WIDTH bits
//   group_i : {b[2j+1], b[2j], b[2j-1]} for this row
//   row_o   : digit*a, sign-extended to 2*WIDTH bits and shifted left by 2*ROW_IDX
// The negation is done entirely inside the row (no separate +1 correction row),
// so the reduction tree only has to add rows modulo 2^(2*WIDTH).
module booth_r4_row
  import pp_gen_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ROW_IDX = 0
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [2:0]         group_i,
  output logic [2*WIDTH-1:0] row_o
);

  localparam int PP_W = 2 * WIDTH;

  booth_digit_e    digit;
  logic [PP_W-1:0] a_ext;
  logic [PP_W-1:0] mag;

  always_comb begin
    digit = booth_decode(group_i);
    a_ext = {{WIDTH{a_i[WIDTH-1]}}, a_i};
    mag   = '0;
    unique case (digit)
      BD_POS1: mag = a_ext;
      BD_POS2: mag = a_ext << 1;
      BD_NEG1: mag = -a_ext;
      // a = -2^(WIDTH-1) gives -2a = 2^WIDTH, which still fits in PP_W bits
      BD_NEG2: mag = -(a_ext << 1);
      default: mag = '0;
    endcase
    row_o = mag << (2 * ROW_IDX);
  end

endmodule

// File: rtl/pp_gen_pipe.sv
// Pipelined partial-product generator for the MAC reduction trees.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   in_valid_i/in_ready_o : operand handshake; in_a_i, in_b_i, in_mode_i carried with it
//   out_valid_o/out_ready_i : row handshake
//   out_pp_o              : ROWS rows of PP_W bits, row r at [r*PP_W +: PP_W]
//   out_rows_o            : number of meaningful rows (WIDTH or WIDTH/2)
//   out_mode_o            : mode of the beat currently on out_pp_o
// Stage 1 holds the raw operands, stage 2 holds the encoded rows. Both stages
// stall together under back-pressure; in_ready_o is combinational from out_ready_i.
module pp_gen_pipe
  import pp_gen_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int PP_W = 2 * WIDTH,
  localparam int ROWS = WIDTH,
  localparam int RW   = $clog2(ROWS + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     in_a_i,
  input  logic [WIDTH-1:0]     in_b_i,
  input  logic                 in_mode_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ROWS*PP_W-1:0] out_pp_o,
  output logic [RW-1:0]        out_rows_o,
  output logic                 out_mode_o
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             mode_q, mode_d;

  logic                 s2_valid_q, s2_valid_d;
  logic [ROWS*PP_W-1:0] pp_q, pp_d;
  logic [RW-1:0]        rows_q, rows_d;
  logic                 omode_q, omode_d;

  logic s2_load;
  logic accept;

  logic [PP_W-1:0]      and_row   [ROWS];
  logic [PP_W-1:0]      booth_row [ROWS/2];
  logic [ROWS*PP_W-1:0] enc_pp;

  assign s2_load    = !s2_valid_q || out_ready_i;
  assign in_ready_o = !s1_valid_q || s2_load;
  assign accept     = in_valid_i && in_ready_o;

  // Unsigned AND-array rows
  for (genvar i = 0; i < ROWS; i++) begin : g_and
    assign and_row[i] = PP_W'(a_q & {WIDTH{b_q[i]}}) << i;
  end

  // Radix-4 Booth rows; the group for row 0 uses an implicit b[-1] = 0
  for (genvar j = 0; j < ROWS/2; j++) begin : g_booth
    logic [2:0] grp;
    if (j == 0) begin : g_first
      assign grp = {b_q[1], b_q[0], 1'b0};
    end else begin : g_rest
      assign grp = b_q[2*j+1 : 2*j-1];
    end
    booth_r4_row #(
      .WIDTH  (WIDTH),
      .ROW_IDX(j)
    ) u_row (
      .a_i    (a_q),
      .group_i(grp),
      .row_o  (booth_row[j])
    );
  end

  // Row mux by mode; Booth mode leaves the upper half of the rows at zero
  for (genvar r = 0; r < ROWS; r++) begin : g_mux
    if (r < ROWS/2) begin : g_lo
      assign enc_pp[r*PP_W +: PP_W] = (mode_q == PP_MODE_BOOTH) ? booth_row[r] : and_row[r];
    end else begin : g_hi
      assign enc_pp[r*PP_W +: PP_W] = (mode_q == PP_MODE_BOOTH) ? '0 : and_row[r];
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    mode_d     = mode_q;
    s2_valid_d = s2_valid_q;
    pp_d       = pp_q;
    rows_d     = rows_q;
    omode_d    = omode_q;

    if (in_ready_o) begin
      s1_valid_d = in_valid_i;
    end
    if (accept) begin
      a_d    = in_a_i;
      b_d    = in_b_i;
      mode_d = in_mode_i;
    end

    // Data only moves when a real beat advances, so held outputs never change
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        pp_d    = enc_pp;
        rows_d  = (mode_q == PP_MODE_BOOTH) ? RW'(ROWS/2) : RW'(ROWS);
        omode_d = mode_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      mode_q     <= 1'b0;
      s2_valid_q <= 1'b0;
      pp_q       <= '0;
      rows_q     <= '0;
      omode_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mode_q     <= mode_d;
      s2_valid_q <= s2_valid_d;
      pp_q       <= pp_d;
      rows_q     <= rows_d;
      omode_q    <= omode_d;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign out_pp_o    = pp_q;
  assign out_rows_o  = rows_q;
  assign out_mode_o  = omode_q;

endmodule
